button_event_ctrl: RTL and testbench

//  Debounce controller for NUM_SW active-low front-panel switches, sharing one tick prescaler.
//  Per-channel FSM turns raw bounces into PRESS / LONG / RELEASE events.

---
 rtl/button_event_pkg.sv | 15 +
 rtl/btn_channel_fsm.sv | 126 ++++++++++++
 rtl/button_event_ctrl.sv | 124 ++++++++++++
 tb/tb_button_event_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/button_event_pkg.sv
// Shared constants for the front-panel button event controller.
// Event codes on the output stream and per-channel FSM state encoding.
package button_event_pkg;

    localparam logic [1:0] EVT_NONE    = 2'd0;
    localparam logic [1:0] EVT_PRESS   = 2'd1;
    localparam logic [1:0] EVT_LONG    = 2'd2;
    localparam logic [1:0] EVT_RELEASE = 2'd3;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT = 2'd1;
    localparam logic [1:0] ST_PRESSED    = 2'd2;
    localparam logic [1:0] ST_REL_WAIT   = 2'd3;

endpackage

// File: rtl/btn_channel_fsm.sv
// One switch channel: 2-FF synchroniser, debounce FSM, hold counter.
// Emits a one-cycle post with its event code on each accepted transition.
module btn_channel_fsm
    import button_event_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 20,
    parameter int LONG_TICKS     = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sw_n,
    input  logic       tick,
    output logic       sw_state,
    output logic       post,
    output logic [1:0] code
);

    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam int HW = $clog2(LONG_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_TICKS);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_TICKS);

    logic [1:0]    sync;
    logic          raw;
    logic [1:0]    state, state_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [HW-1:0] hold, hold_n, hold_inc;
    logic          long_sent, long_sent_n;
    logic          pressed_n;

    assign raw = ~sync[1];

    // Bring the asynchronous pin into the clock domain, idle = released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= 2'b11;
        else        sync <= {sync[0], sw_n};
    end

    // Saturating increments so the counters can never wrap.
    always_comb begin
        cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        hold_inc = (hold == HOLD_MAX) ? hold : hold + 1'b1;
    end

    // Next-state logic; a raw level change always beats a coincident tick.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        hold_n      = hold;
        long_sent_n = long_sent;
        pressed_n   = sw_state;
        post        = 1'b0;
        code        = EVT_NONE;
        case (state)
            ST_IDLE: begin
                if (raw) begin
                    state_n = ST_PRESS_WAIT;
                    cnt_n   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!raw) begin
                    state_n = ST_IDLE;
                end else if (tick) begin
                    if (cnt == CNT_LAST) begin
                        state_n     = ST_PRESSED;
                        pressed_n   = 1'b1;
                        post        = 1'b1;
                        code        = EVT_PRESS;
                        hold_n      = '0;
                        long_sent_n = 1'b0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
            end
            ST_PRESSED: begin
                if (!raw) begin
                    state_n = ST_REL_WAIT;
                    cnt_n   = '0;
                end else if (tick && !long_sent) begin
                    hold_n = hold_inc;
                    if (hold_inc == HOLD_MAX) begin
                        post        = 1'b1;
                        code        = EVT_LONG;
                        long_sent_n = 1'b1;
                    end
                end
            end
            default: begin
                if (raw) begin
                    state_n = ST_PRESSED;
                    cnt_n   = '0;
                end else if (tick) begin
                    if (cnt == CNT_LAST) begin
                        state_n   = ST_IDLE;
                        pressed_n = 1'b0;
                        post      = 1'b1;
                        code      = EVT_RELEASE;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
            end
        endcase
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            hold      <= '0;
            long_sent <= 1'b0;
            sw_state  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            hold      <= hold_n;
            long_sent <= long_sent_n;
            sw_state  <= pressed_n;
        end
    end

endmodule

// File: rtl/button_event_ctrl.sv
// Debounced button event controller: shared tick prescaler, per-channel
// FSMs, one pending code per channel, round-robin onto a valid/ready stream.
module button_event_ctrl
    import button_event_pkg::*;
#(
    parameter int NUM_SW         = 4,
    parameter int CLOCK_RATE_HZ  = 50_000_000,
    parameter int TICK_HZ        = 1000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int LONG_TICKS     = 1000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SW-1:0]         sw_n,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [$clog2(NUM_SW)-1:0] evt_id,
    output logic [1:0]                evt_code,
    output logic [NUM_SW-1:0]         sw_state,
    output logic                      overrun
);

    localparam int TICK_DIV = CLOCK_RATE_HZ / TICK_HZ;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW = $clog2(NUM_SW);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [IW:0]   NSW      = (IW + 1)'(NUM_SW);

    logic [PW-1:0]     presc;
    logic              tick;
    logic [NUM_SW-1:0] post;
    logic [1:0]        post_code [NUM_SW];
    logic [1:0]        pend [NUM_SW];
    logic [NUM_SW-1:0] busy, clr;
    logic [IW-1:0]     ptr, gnt;
    logic [IW:0]       scan;
    logic              found, load;

    assign tick = (presc == PRE_LAST);
    assign load = !evt_valid || evt_ready;

    // Free-running prescaler shared by every channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + 1'b1;
    end

    for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
        btn_channel_fsm #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
            .LONG_TICKS    (LONG_TICKS)
        ) u_fsm (
            .clk     (clk),
            .rst_n   (rst_n),
            .sw_n    (sw_n[i]),
            .tick    (tick),
            .sw_state(sw_state[i]),
            .post    (post[i]),
            .code    (post_code[i])
        );
    end

    // Round-robin scan of pending codes starting at the pointer.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        scan  = '0;
        for (int k = 0; k < NUM_SW; k++) begin
            scan = {1'b0, ptr} + (IW + 1)'(k);
            if (scan >= NSW) scan = scan - NSW;
            if (!found && busy[scan[IW-1:0]]) begin
                found = 1'b1;
                gnt   = scan[IW-1:0];
            end
        end
    end

    // Occupancy and grant-clear per channel.
    always_comb begin
        busy = '0;
        clr  = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            busy[i] = (pend[i] != EVT_NONE);
            clr[i]  = load && found && (gnt == IW'(i));
        end
    end

    // Pending codes: a fresh post wins over a same-cycle grant clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SW; i++) pend[i] <= EVT_NONE;
        end else begin
            for (int i = 0; i < NUM_SW; i++) begin
                if (post[i])     pend[i] <= post_code[i];
                else if (clr[i]) pend[i] <= EVT_NONE;
            end
        end
    end

    // Flag a post that replaced a code nobody has taken yet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overrun <= 1'b0;
        else        overrun <= |(post & busy & ~clr);
    end

    // Output register and pointer advance past the granted channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid <= 1'b0;
            evt_id    <= '0;
            evt_code  <= EVT_NONE;
            ptr       <= '0;
        end else if (load) begin
            evt_valid <= found;
            if (found) begin
                evt_id   <= gnt;
                evt_code <= pend[gnt];
                ptr      <= (gnt == IW'(NUM_SW - 1)) ? '0 : gnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Bench for button_event_ctrl: vector table of press patterns plus
// hand sequences for bounce, arbitration, backpressure and reset.
module tb_button_event_ctrl;

    localparam logic [1:0] P = 2'd1;
    localparam logic [1:0] L = 2'd2;
    localparam logic [1:0] R = 2'd3;

    typedef struct {
        logic [1:0] id;
        logic [1:0] code;
    } evt_t;

    typedef struct {
        logic [1:0] ch;
        int         hold;
        logic       exp_press;
        logic       exp_long;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw_n;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_id;
    logic [1:0] evt_code;
    logic [3:0] sw_state;
    logic       overrun;

    evt_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   ev_count = 0;
    int   ovr_count = 0;

    always #5 clk = ~clk;

    button_event_ctrl #(
        .NUM_SW        (4),
        .CLOCK_RATE_HZ (10_000),
        .TICK_HZ       (1000),
        .DEBOUNCE_TICKS(3),
        .LONG_TICKS    (10)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw_n     (sw_n),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_id   (evt_id),
        .evt_code (evt_code),
        .sw_state (sw_state),
        .overrun  (overrun)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic push(input logic [1:0] id, input logic [1:0] code);
        evt_t e;
        e.id = id;
        e.code = code;
        exp_q.push_back(e);
    endtask

    // Inputs are stable here; these are the values the next posedge uses.
    task automatic step();
        evt_t e;
        if (rst_n && evt_valid && evt_ready) begin
            ev_count++;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_evt: got id=%0d code=%0d, required none",
                         evt_id, evt_code);
            end else begin
                e = exp_q.pop_front();
                chk("evt_id_code", {28'd0, evt_id, evt_code}, {28'd0, e.id, e.code});
            end
        end
        if (rst_n && overrun) ovr_count++;
        @(negedge clk);
    endtask

    task automatic cycles(input int n);
        repeat (n) step();
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (evt_valid) break;
            step();
        end
        chk("wait_valid", {31'd0, evt_valid}, 32'd1);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !evt_valid) break;
            step();
        end
        chk("drain_left", exp_q.size(), 32'd0);
        exp_q.delete();
        cycles(20);
    endtask

    vec_t vecs[5];
    int   ev0;
    logic [1:0] cap_id, cap_code;
    logic stable;

    initial begin
        vecs[0] = '{ch: 2'd0, hold: 60,  exp_press: 1'b1, exp_long: 1'b0};
        vecs[1] = '{ch: 2'd2, hold: 150, exp_press: 1'b1, exp_long: 1'b1};
        vecs[2] = '{ch: 2'd3, hold: 15,  exp_press: 1'b0, exp_long: 1'b0};
        vecs[3] = '{ch: 2'd1, hold: 60,  exp_press: 1'b1, exp_long: 1'b0};
        vecs[4] = '{ch: 2'd2, hold: 14,  exp_press: 1'b0, exp_long: 1'b0};

        rst_n = 1'b0;
        sw_n = 4'hF;
        evt_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, evt_valid}, 32'd0);
        chk("rst_id_code", {28'd0, evt_id, evt_code}, 32'd0);
        chk("rst_sw_state", {28'd0, sw_state}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        rst_n = 1'b1;
        evt_ready = 1'b1;
        cycles(200);
        chk("idle_no_evt", ev_count, 32'd0);

        // Bounce on ch1: each stable stretch is shorter than the debounce.
        ev0 = ev_count;
        for (int i = 0; i < 14; i++) begin
            sw_n[1] = ~sw_n[1];
            cycles(7);
        end
        chk("bounce_no_evt", ev_count - ev0, 32'd0);
        chk("bounce_sw_state", {31'd0, sw_state[1]}, 32'd0);
        sw_n[1] = 1'b0;
        push(2'd1, P);
        wait_valid(60);
        chk("bounce_sw_state_up", {31'd0, sw_state[1]}, 32'd1);
        cycles(20);
        sw_n[1] = 1'b1;
        push(2'd1, R);
        drain(100);
        chk("bounce_evt_count", ev_count - ev0, 32'd2);

        // Single-channel vectors.
        for (int v = 0; v < 5; v++) begin
            sw_n[vecs[v].ch] = 1'b0;
            if (vecs[v].exp_press) push(vecs[v].ch, P);
            if (vecs[v].exp_long) push(vecs[v].ch, L);
            cycles(vecs[v].hold);
            chk("vec_sw_state", {31'd0, sw_state[vecs[v].ch]},
                {31'd0, vecs[v].exp_press});
            sw_n[vecs[v].ch] = 1'b1;
            if (vecs[v].exp_press) push(vecs[v].ch, R);
            drain(150);
            chk("vec_released", {28'd0, sw_state}, 32'd0);
        end

        // Backpressure: PRESS is held stable while LONG waits pending.
        ovr_count = 0;
        evt_ready = 1'b0;
        sw_n[1] = 1'b0;
        push(2'd1, P);
        push(2'd1, L);
        wait_valid(60);
        cap_id = evt_id;
        cap_code = evt_code;
        stable = 1'b1;
        for (int i = 0; i < 150; i++) begin
            step();
            if (!evt_valid || evt_id != cap_id || evt_code != cap_code)
                stable = 1'b0;
        end
        chk("held_id_code", {28'd0, cap_id, cap_code}, {28'd0, 2'd1, P});
        chk("held_stable", {31'd0, stable}, 32'd1);
        evt_ready = 1'b1;
        drain(40);

        // Backpressure with overwrite: LONG replaces an untaken PRESS.
        evt_ready = 1'b0;
        sw_n[1] = 1'b1;
        push(2'd1, R);
        cycles(50);
        sw_n[1] = 1'b0;
        cycles(200);
        push(2'd1, L);
        evt_ready = 1'b1;
        drain(40);
        chk("overrun_pulses", ovr_count, 32'd1);
        sw_n[1] = 1'b1;
        push(2'd1, R);
        drain(100);

        // Reset mid-operation with an event on the output.
        evt_ready = 1'b0;
        sw_n[1] = 1'b0;
        wait_valid(60);
        sw_n[0] = 1'b0;
        cycles(12);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, evt_valid}, 32'd0);
        chk("async_rst_sw_state", {28'd0, sw_state}, 32'd0);
        sw_n = 4'hF;
        @(negedge clk);
        cycles(3);
        rst_n = 1'b1;
        evt_ready = 1'b1;
        ev0 = ev_count;
        cycles(100);
        chk("post_rst_no_evt", ev_count - ev0, 32'd0);

        // Arbitration from pointer 0, then from pointer 2.
        sw_n[0] = 1'b0;
        sw_n[3] = 1'b0;
        push(2'd0, P);
        push(2'd3, P);
        cycles(40);
        sw_n[1] = 1'b0;
        push(2'd1, P);
        cycles(40);
        sw_n[0] = 1'b1;
        sw_n[3] = 1'b1;
        push(2'd3, R);
        push(2'd0, R);
        cycles(50);
        sw_n[1] = 1'b1;
        push(2'd1, R);
        drain(100);
        chk("final_sw_state", {28'd0, sw_state}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
